modulo_decodificador_contador4bits: RTL and testbench

- Consumer end of the 4-bit counter command code produced by the counter encoder.
- Registers the code on a strobe and decodes it into clear, load and direction commands.
- Runs a 4-bit synchronous up/down counter advanced by an external tick, with a mode FSM and a terminal-count pulse.
- Output feeds the display/decoder stage of the counter subsystem.

---
 rtl/modulo_decodificador_contador4bits.sv | 102 ++++++++++
 tb/tb_modulo_decodificador_contador4bits.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/modulo_decodificador_contador4bits.sv
// Command decoder and 4-bit up/down counter. A strobed command code
// selects clear/load/direction; an external tick steps the count in the current mode.
module modulo_decodificador_contador4bits #(
    parameter int MAX_COUNT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       code_valid,
    input  logic       tick,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic [1:0] mode,
    output logic       tc,
    output logic       err
);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10,
        ERRO     = 2'b11
    } mode_e;

    localparam logic [3:0] MAX_C = 4'(MAX_COUNT);

    mode_e      state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       tc_q, tc_d;
    logic       err_q, err_d;

    // Next-state: a command cycle takes precedence and suppresses any tick step
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (code_valid) begin
            if (code[0]) begin
                count_d = 4'd0;
                state_d = PARADO;
            end else begin
                if (code[2]) begin
                    count_d = (load_value > MAX_C) ? MAX_C : load_value;
                end else begin
                    count_d = count_q;
                end
                case ({code[3], code[1]})
                    2'b10:   state_d = SUBINDO;
                    2'b01:   state_d = DESCENDO;
                    2'b11:   state_d = ERRO;
                    default: state_d = PARADO;
                endcase
            end
        end else if (tick) begin
            case (state_q)
                SUBINDO: begin
                    if (count_q >= MAX_C) begin
                        count_d = 4'd0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
                DESCENDO: begin
                    if (count_q == 4'd0) begin
                        count_d = MAX_C;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            count_d = count_q;
        end
        err_d = (state_d == ERRO);
    end

    // State, count and flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PARADO;
            count_q <= 4'd0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign mode  = state_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_modulo_decodificador_contador4bits.sv
// Scoreboard bench: two instances (MAX_COUNT 15 and 9) share stimulus; a driver
// pushes model-predicted outputs per edge and a monitor compares after each edge.
module tb_modulo_decodificador_contador4bits;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] code = 4'd0;
    logic       code_valid = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] count_a, count_b;
    logic [1:0] mode_a, mode_b;
    logic       tc_a, tc_b, err_a, err_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int count;
        int mode;
        int tc;
    } model_t;

    typedef struct {
        model_t a;
        model_t b;
    } exp_t;

    exp_t   sb_q[$];
    model_t ma = '{0, 0, 0};
    model_t mb = '{0, 0, 0};

    always #5 clk = ~clk;

    modulo_decodificador_contador4bits #(.MAX_COUNT(15)) dut_a (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid), .tick(tick),
        .load_value(load_value), .count(count_a), .mode(mode_a), .tc(tc_a), .err(err_a)
    );

    modulo_decodificador_contador4bits #(.MAX_COUNT(9)) dut_b (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid), .tick(tick),
        .load_value(load_value), .count(count_b), .mode(mode_b), .tc(tc_b), .err(err_b)
    );

    // Reference: modes 0 stopped, 1 up, 2 down, 3 error
    function automatic model_t mstep(model_t s, int mx, bit r, bit cv, bit [3:0] c, bit t, int lv);
        model_t n = s;
        n.tc = 0;
        if (r) begin
            n.count = 0;
            n.mode  = 0;
        end else if (cv) begin
            if (c[0]) begin
                n.count = 0;
                n.mode  = 0;
            end else begin
                if (c[2]) n.count = (lv > mx) ? mx : lv;
                if (c[3] && c[1]) n.mode = 3;
                else if (c[3])    n.mode = 1;
                else if (c[1])    n.mode = 2;
                else              n.mode = 0;
            end
        end else if (t) begin
            if (s.mode == 1) begin
                if (s.count == mx) begin n.count = 0; n.tc = 1; end
                else n.count = s.count + 1;
            end else if (s.mode == 2) begin
                if (s.count == 0) begin n.count = mx; n.tc = 1; end
                else n.count = s.count - 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(bit r, bit cv, bit [3:0] c, bit t, int lv);
        exp_t e;
        @(negedge clk);
        rst = r; code_valid = cv; code = c; tick = t; load_value = 4'(lv);
        ma = mstep(ma, 15, r, cv, c, t, lv);
        mb = mstep(mb, 9, r, cv, c, t, lv);
        e.a = ma;
        e.b = mb;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count15", int'(count_a), e.a.count);
                chk("mode15",  int'(mode_a),  e.a.mode);
                chk("tc15",    int'(tc_a),    e.a.tc);
                chk("err15",   int'(err_a),   (e.a.mode == 3) ? 1 : 0);
                chk("count9",  int'(count_b), e.b.count);
                chk("mode9",   int'(mode_b),  e.b.mode);
                chk("tc9",     int'(tc_b),    e.b.tc);
                chk("err9",    int'(err_b),   (e.b.mode == 3) ? 1 : 0);
            end
        end
    end

    initial begin
        int wait_cycles;
        // Count up through wrap
        cyc(1, 0, 4'b0000, 0, 0);
        cyc(0, 1, 4'b1000, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 4'b0000, 1, 0);
        cyc(0, 0, 4'b0000, 0, 0);
        // Load 3 and count down through wrap
        cyc(0, 1, 4'b0110, 0, 3);
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'b0000, 1, 0);
        cyc(0, 0, 4'b0000, 0, 0);
        // Illegal direction, ticks ignored, then clear
        cyc(0, 1, 4'b1010, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000, 1, 0);
        cyc(0, 1, 4'b0001, 0, 0);
        // Saturating load above MAX_COUNT then tick
        cyc(0, 1, 4'b1100, 0, 12);
        cyc(0, 0, 4'b0000, 1, 0);
        cyc(0, 0, 4'b0000, 0, 0);
        // Command and tick together: tick ignored
        cyc(0, 1, 4'b0100, 0, 5);
        cyc(0, 1, 4'b1000, 1, 0);
        cyc(0, 0, 4'b0000, 1, 0);
        // Reset mid-count with tick
        cyc(0, 1, 4'b1100, 0, 7);
        cyc(1, 0, 4'b0000, 1, 0);
        cyc(0, 0, 4'b0000, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
                int'($urandom_range(0, 15)));
        end
        cyc(0, 0, 4'b0000, 0, 0);
        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
